// File: rtl/pipe_adder.sv
// pipe_adder: pipelined unsigned adder, one CHUNK-bit ripple slice per stage.
// The WIDTH-bit operands travel down the pipe with the item; each stage adds
// its own slice, leaves the lower sum slices in place and passes its carry on.
// A single global advance signal moves every stage together, so results
// leave in acceptance order and a full pipe can take and accept in one cycle.
//
// Optional feature: define PIPE_ADDER_SUB_EN to add the 'sub' input. With
// sub=1 the item computes a + ~b + 1. out[WIDTH] then reads 1 when there is
// no borrow (a >= b).
module pipe_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out
);

    // Guarded divisor keeps the stage count well defined even for a bad CHUNK;
    // the check below then stops elaboration.
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int STAGES     = (WIDTH / CHUNK_SAFE < 1) ? 1 : WIDTH / CHUNK_SAFE;

    if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
        $error("pipe_adder: WIDTH must be a positive multiple of CHUNK (CHUNK >= 1)");
    end

    // Global advance: the pipe moves when the output slot is empty or being taken.
    logic adv;

    // Operand B as fed to stage 0 (inverted for subtraction) and the stage-0 carry-in.
    logic [WIDTH-1:0] in_b_eff;
    logic             in_cin;

    // Per-stage registered state.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    // What each stage would load on an advance: stage 0 from the inputs,
    // stage k from the register of stage k-1.
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [STAGES-1:0] src_carry;
    logic [STAGES-1:0] src_valid;

    // Slice adder results: {carry_out, slice_sum}.
    logic [CHUNK_SAFE:0] slice_res [STAGES];

    assign out_valid = valid_q[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out       = {carry_q[STAGES-1], sum_q[STAGES-1]};

    // Prepare stage-0 operands: subtraction is add of the inverted B with carry-in 1.
    always_comb begin
`ifdef PIPE_ADDER_SUB_EN
        in_b_eff = sub ? ~b : b;
        in_cin   = sub;
`else
        in_b_eff = b;
        in_cin   = 1'b0;
`endif
    end

    // Select the data each stage sees at its input (skewed operand/sum hand-off).
    always_comb begin
        src_carry = '0;
        src_valid = '0;
        src_a[0]     = a;
        src_b[0]     = in_b_eff;
        src_sum[0]   = '0;
        src_carry[0] = in_cin;
        src_valid[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_sum[k]   = sum_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
    end

    // One ripple slice per stage, working on that stage's own bit range.
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        assign slice_res[k] = {1'b0, src_a[k][k*CHUNK_SAFE +: CHUNK_SAFE]}
                            + {1'b0, src_b[k][k*CHUNK_SAFE +: CHUNK_SAFE]}
                            + {{CHUNK_SAFE{1'b0}}, src_carry[k]};
    end

    // Next state: hold everything when stalled, otherwise shift every stage by one.
    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
        end
        if (adv) begin
            valid_d = src_valid;
            for (int k = 0; k < STAGES; k++) begin
                a_d[k]   = src_a[k];
                b_d[k]   = src_b[k];
                sum_d[k] = src_sum[k];
                sum_d[k][k*CHUNK_SAFE +: CHUNK_SAFE] = slice_res[k][CHUNK_SAFE-1:0];
                carry_d[k] = slice_res[k][CHUNK_SAFE];
            end
        end
    end

    // Pipeline registers; reset discards every in-flight item.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed + randomized bench for pipe_adder with a queue-based
// reference model. Subtraction cases are included when PIPE_ADDER_SUB_EN is defined.
module tb_pipe_adder;

    localparam int WIDTH   = 8;
    localparam int CHUNK   = 2;
    localparam int LATENCY = WIDTH / CHUNK;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub_s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out;

    pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
`ifdef PIPE_ADDER_SUB_EN
        .sub      (sub_s),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH:0] exp_q[$];
    logic           prev_stalled = 1'b0;
    logic [WIDTH:0] prev_out     = '0;
    logic           seen_out     = 1'b0;
    logic [WIDTH:0] last_taken   = '0;
    int             taken        = 0;
    int             accepted     = 0;

    // Reference: plain arithmetic sum, or difference with a no-borrow flag.
    function automatic logic [WIDTH:0] refResult(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic s);
        int unsigned    total;
        logic [WIDTH-1:0] diff;
        if (s) begin
            diff = x - y;
            return {(x >= y), diff};
        end
        total = int'(x) + int'(y);
        return total[WIDTH:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inspect outputs for the cycle just sampled and retire taken results.
    task automatic checkOutput();
        seen_out = out_valid;
        if (prev_stalled) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out), 32'(prev_out));
        end
        check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
            check("no_stale", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("result", 32'(out), 32'(exp_q.pop_front()));
            last_taken = out;
            taken++;
        end
        prev_stalled = out_valid && !out_ready;
        prev_out     = out;
    endtask

    // One clock cycle: drive on the falling edge, sample shortly after.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] aa,
                                 input logic [WIDTH-1:0] bb, input logic s, input logic ordy);
        @(negedge clock);
        in_valid  = v;
        a         = aa;
        b         = bb;
        sub_s     = s;
        out_ready = ordy;
        #1;
        checkOutput();
        if (in_valid && in_ready) begin
            exp_q.push_back(refResult(a, b, sub_s));
            accepted++;
        end
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 2 * LATENCY; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int dropped;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub_s     = 1'b0;
        out_ready = 1'b1;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out", 32'(out), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] single beat latency");
        applyStimulus(1'b1, 8'h03, 8'h01, 1'b0, 1'b1);
        lat = 0;
        seen_out = 1'b0;
        while (!seen_out && lat < 20) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
            lat++;
        end
        check("latency", 32'(lat), 32'(LATENCY));
        check("first_result", 32'(last_taken), 32'h004);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        check("one_beat", 32'(seen_out), 32'd0);

        $display("[TB] carry ripple corners");
        applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        drain(40);
        check("ripple_last", 32'(last_taken), 32'h100);

        $display("[TB] back-to-back stream");
        taken = 0;
        accepted = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        drain(40);
        check("stream_accepted", 32'(accepted), 32'd16);
        check("stream_taken", 32'(taken), 32'd16);

        $display("[TB] output stall");
        taken = 0;
        accepted = 0;
        dropped = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0);
            if (!in_ready) dropped++;
        end
        check("stall_dropped", 32'(dropped > 0), 32'd1);
        drain(40);
        check("stall_count", 32'(taken), 32'(accepted));

        $display("[TB] random back-pressure");
        taken = 0;
        accepted = 0;
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b0,
                          ($urandom_range(0, 3) != 0));
        end
        drain(80);
        check("random_count", 32'(taken), 32'(accepted));

        $display("[TB] async reset mid-stream");
        for (int i = 0; i < LATENCY; i++)
            applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
        #2;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_out", 32'(out), 32'd0);
        exp_q.delete();
        prev_stalled = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        drain(10);

`ifdef PIPE_ADDER_SUB_EN
        $display("[TB] subtraction");
        applyStimulus(1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
        drain(20);
        check("sub_borrow", 32'(last_taken), 32'h0FE);
        applyStimulus(1'b1, 8'h07, 8'h05, 1'b1, 1'b1);
        drain(20);
        check("sub_no_borrow", 32'(last_taken), 32'h102);
        taken = 0;
        accepted = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        drain(80);
        check("mixed_count", 32'(taken), 32'(accepted));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
